// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset
//   op     in   3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   a      in  32  multiplicand / dividend / MTHI-MTLO data
//   b      in  32  multiplier / divisor
//   start  in   1  request, sampled with op/a/b
//   busy   out  1  iterative operation in progress
//   done   out  1  one-cycle pulse when hi/lo receive a MULT/DIV result
//   hi     out 32  product upper word or remainder
//   lo     out 32  product lower word or quotient
//
// Build option: MULDIV_SIGNED_EN makes MULT/DIV signed; without it they
// behave as MULTU/DIVU.

module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    logic [4:0]  cnt;
    // Working register: multiply keeps {partial sum, multiplier}, divide
    // keeps {remainder, dividend/quotient}; both shift one bit per cycle.
    logic [63:0] p;
    logic [31:0] opb;      // multiplicand or divisor magnitude
    logic [31:0] a_lat;    // raw dividend, returned as hi on divide by zero
    logic        is_div;

    logic        op_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] add_sum;
    logic [32:0] div_shift;
    logic [32:0] sub_diff;
    logic [63:0] p_step;

    logic [63:0] res_mul;
    logic [31:0] res_q;
    logic [31:0] res_r;

`ifdef MULDIV_SIGNED_EN
    logic op_signed;
    logic neg_res;   // product or quotient must be negated
    logic neg_rem;   // remainder takes the dividend's sign
`endif

    // Operand magnitudes latched at E0; the iteration itself is unsigned.
    always_comb begin
        op_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_SIGNED_EN
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag = (op_signed && a[31]) ? (32'd0 - a) : a;
        b_mag = (op_signed && b[31]) ? (32'd0 - b) : b;
`else
        a_mag = a;
        b_mag = b;
`endif
    end

    // One radix-2 step. The restoring divide compares the shifted remainder
    // against the divisor in 33 bits; bit 32 of the difference is the borrow.
    always_comb begin
        add_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, opb} : 33'd0);
        div_shift = {p[63:32], p[31]};
        sub_diff  = div_shift - {1'b0, opb};
        if (is_div) begin
            if (!sub_diff[32]) begin
                p_step = {sub_diff[31:0], p[30:0], 1'b1};
            end else begin
                p_step = {div_shift[31:0], p[30:0], 1'b0};
            end
        end else begin
            p_step = {add_sum, p[31:1]};
        end
    end

    always_comb begin
        res_mul = p_step;
        res_q   = p_step[31:0];
        res_r   = p_step[63:32];
`ifdef MULDIV_SIGNED_EN
        if (neg_res) begin
            res_mul = 64'd0 - p_step;
            res_q   = 32'd0 - p_step[31:0];
        end
        if (neg_rem) begin
            res_r = 32'd0 - p_step[63:32];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 5'd0;
            p      <= 64'd0;
            opb    <= 32'd0;
            a_lat  <= 32'd0;
            is_div <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state  <= S_RUN;
                                busy   <= 1'b1;
                                cnt    <= 5'd0;
                                p      <= {32'd0, a_mag};
                                opb    <= b_mag;
                                a_lat  <= a;
                                is_div <= op_div;
`ifdef MULDIV_SIGNED_EN
                                neg_res <= op_signed && (a[31] ^ b[31]);
                                neg_rem <= op_signed && op_div && a[31];
`endif
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    p <= p_step;
                    if (cnt == 5'd31) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_div) begin
                            // Divide by zero is forced so the signed fixup
                            // cannot disturb the defined result.
                            if (opb == 32'd0) begin
                                hi <= a_lat;
                                lo <= 32'hFFFF_FFFF;
                            end else begin
                                hi <= res_r;
                                lo <= res_q;
                            end
                        end else begin
                            hi <= res_mul[63:32];
                            lo <= res_mul[31:0];
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
